// File: rtl/alu_exec_mc_if.sv
// Request/response bundle for the multi-cycle ALU execute unit.
// The master modport is the requester side; the slave modport is the ALU itself.
interface alu_exec_mc_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       Op_ALU;
   logic [15:0]      Campo_16_Bits;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             valid_out;
   logic [WIDTH-1:0] resultado;
   logic             zero;
   logic [3:0]       saida_alu_control;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             illegal;

   modport master (
      output start, Op_ALU, Campo_16_Bits, A, B,
      input  ready, valid_out, resultado, zero, saida_alu_control, hi, lo, illegal
   );

   modport slave (
      input  start, Op_ALU, Campo_16_Bits, A, B,
      output ready, valid_out, resultado, zero, saida_alu_control, hi, lo, illegal
   );
endinterface

// File: rtl/alu_exec_mc.sv
// MIPS-style ALU execute stage: single-cycle logic/arith ops plus an optional
// shift-add multiplier with HI/LO registers, enabled by defining ALU_EXEC_MULT_EN.
module alu_exec_mc #(
   parameter int WIDTH = 32
) (
   input logic         clock,
   input logic         reset_n,
   alu_exec_mc_if.slave bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MFHI = 4'b1010;
   localparam logic [3:0] OP_MFLO = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_ILL  = 4'b1111;
`ifdef ALU_EXEC_MULT_EN
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam int         CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
      logic [3:0] code;
      case (op)
         2'b00: code = OP_ADD;
         2'b01: code = OP_SUB;
         2'b10: begin
            case (funct)
               6'b100000: code = OP_ADD;
               6'b100010: code = OP_SUB;
               6'b100100: code = OP_AND;
               6'b100101: code = OP_OR;
               6'b101010: code = OP_SLT;
               6'b100111: code = OP_NOR;
`ifdef ALU_EXEC_MULT_EN
               6'b010000: code = OP_MFHI;
               6'b010010: code = OP_MFLO;
               6'b011000: code = OP_MULT;
               6'b011001: code = OP_MULTU;
`endif
               default:   code = OP_ILL;
            endcase
         end
         default: code = OP_ILL;
      endcase
      return code;
   endfunction

   state_t                  state, next_state;
   logic                    ready_c, accept, single_acc, mul_req;
   logic [3:0]              dec_code;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH-1:0]        alu_res;
   logic [WIDTH-1:0]        hi_q, lo_q;
   logic                    vld_p1, zero_p1, ill_p1;
   logic [WIDTH-1:0]        res_p1;
   logic [3:0]              code_p1;
   logic                    unused_field;

   // Only the funct bits of the immediate field are meaningful here.
   assign unused_field = ^bus.Campo_16_Bits[15:6];

   assign dec_code   = alu_decode(bus.Op_ALU, bus.Campo_16_Bits[5:0]);
   assign a_s        = bus.A;
   assign b_s        = bus.B;
   assign single_acc = accept & ~mul_req;

   always_comb begin
      alu_res = '0;
      case (dec_code)
         OP_ADD:  alu_res = bus.A + bus.B;
         OP_SUB:  alu_res = bus.A - bus.B;
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_NOR:  alu_res = ~(bus.A | bus.B);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_EXEC_MULT_EN
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      m = v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
      return m;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] p, input logic n);
      return n ? -p : p;
   endfunction

   logic                   ld_mul, iter, finish;
   logic [CNT_W-1:0]       cnt;
   logic [WIDTH-1:0]       mcand_p0, prod_hi_p0, prod_lo_p0;
   logic                   neg_p0;
   logic [WIDTH:0]         step_sum;
   logic [2*WIDTH-1:0]     prod_fin;

   assign mul_req  = (dec_code == OP_MULT) || (dec_code == OP_MULTU);
   assign step_sum = {1'b0, prod_hi_p0} + (prod_lo_p0[0] ? {1'b0, mcand_p0} : '0);
   assign prod_fin = cond_neg({prod_hi_p0, prod_lo_p0}, neg_p0);

   // Stage p0: iterative shift-add on magnitudes; the sign is applied once at the end.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         mcand_p0   <= '0;
         prod_hi_p0 <= '0;
         prod_lo_p0 <= '0;
         neg_p0     <= 1'b0;
      end else if (ld_mul) begin
         cnt        <= '0;
         prod_hi_p0 <= '0;
         if (dec_code == OP_MULT) begin
            mcand_p0   <= magnitude(a_s);
            prod_lo_p0 <= magnitude(b_s);
            neg_p0     <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
         end else begin
            mcand_p0   <= bus.A;
            prod_lo_p0 <= bus.B;
            neg_p0     <= 1'b0;
         end
      end else if (iter) begin
         prod_hi_p0 <= step_sum[WIDTH:1];
         prod_lo_p0 <= {step_sum[0], prod_lo_p0[WIDTH-1:1]};
         cnt        <= cnt + CNT_W'(1);
      end
   end
`else
   assign mul_req = 1'b0;
   assign hi_q    = '0;
   assign lo_q    = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready_c    = 1'b0;
      accept     = 1'b0;
`ifdef ALU_EXEC_MULT_EN
      ld_mul     = 1'b0;
      iter       = 1'b0;
      finish     = 1'b0;
`endif
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.start) begin
               accept = 1'b1;
`ifdef ALU_EXEC_MULT_EN
               if (mul_req) begin
                  ld_mul     = 1'b1;
                  next_state = MUL;
               end
`endif
            end
         end
`ifdef ALU_EXEC_MULT_EN
         MUL: begin
            iter = 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) next_state = DONE;
         end
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Stage p1: registered results, visible the cycle after the accept or finish edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         res_p1  <= '0;
         zero_p1 <= 1'b1;
         ill_p1  <= 1'b0;
         code_p1 <= '0;
`ifdef ALU_EXEC_MULT_EN
         hi_q    <= '0;
         lo_q    <= '0;
`endif
      end else begin
         vld_p1 <= 1'b0;
         if (accept) code_p1 <= dec_code;
         if (single_acc) begin
            res_p1  <= alu_res;
            zero_p1 <= (alu_res == '0);
            ill_p1  <= (dec_code == OP_ILL);
            vld_p1  <= 1'b1;
         end
`ifdef ALU_EXEC_MULT_EN
         if (finish) begin
            hi_q    <= prod_fin[2*WIDTH-1:WIDTH];
            lo_q    <= prod_fin[WIDTH-1:0];
            res_p1  <= prod_fin[WIDTH-1:0];
            zero_p1 <= (prod_fin[WIDTH-1:0] == '0);
            ill_p1  <= 1'b0;
            vld_p1  <= 1'b1;
         end
`endif
      end
   end

   assign bus.ready             = ready_c;
   assign bus.valid_out         = vld_p1;
   assign bus.resultado         = res_p1;
   assign bus.zero              = zero_p1;
   assign bus.illegal           = ill_p1;
   assign bus.saida_alu_control = code_p1;
   assign bus.hi                = hi_q;
   assign bus.lo                = lo_q;

endmodule
